// File: rtl/card_match_pkg.sv
// card_match_pkg: shared scheduler state encoding, rank widths and rank index constants
package card_match_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, DONE} state_t;
  localparam int NUM_RANKS = 13;
  localparam int RANK_SCORE_W = 11;
  localparam int RANK_A = 0;
  localparam int RANK_2 = 1;
  localparam int RANK_3 = 2;
  localparam int RANK_4 = 3;
  localparam int RANK_5 = 4;
  localparam int RANK_6 = 5;
  localparam int RANK_7 = 6;
  localparam int RANK_8 = 7;
  localparam int RANK_9 = 8;
  localparam int RANK_10 = 9;
  localparam int RANK_J = 10;
  localparam int RANK_Q = 11;
  localparam int RANK_K = 12;
endpackage

// File: rtl/match_min_tracker.sv
// match_min_tracker: running minimum score and its index; strict compare keeps the earlier index on ties
module match_min_tracker
  import card_match_pkg::*;
#(
  parameter int SCORE_W = RANK_SCORE_W,
  parameter int IDX_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               upd_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [SCORE_W-1:0] best_score_nxt_o,
  output logic [IDX_W-1:0]   best_idx_nxt_o
);
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic               take;
  // next best: clear to all-ones, or take a strictly smaller score
  always_comb begin
    take = upd_i && (score_i < best_score_q);
    best_score_d = clear_i ? '1 : take ? score_i : best_score_q;
    best_idx_d = clear_i ? '0 : take ? idx_i : best_idx_q;
  end
  // best-so-far registers
  always_ff @(posedge clk) begin
    if (rst) begin
      best_score_q <= '1;
      best_idx_q <= '0;
    end else begin
      best_score_q <= best_score_d;
      best_idx_q <= best_idx_d;
    end
  end
  assign best_score_nxt_o = best_score_d;
  assign best_idx_nxt_o = best_idx_d;
endmodule

// File: rtl/rank_match_scheduler.sv
// rank_match_scheduler: runs the shared scorer over every rank kernel and reports the best match (optional MATCH_THRESHOLD_EN adds no_match)
module rank_match_scheduler
  import card_match_pkg::*;
#(
  parameter int NUM_KERNELS = NUM_RANKS,
  parameter int SCORE_WIDTH = RANK_SCORE_W,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int THRESHOLD = 300,
  localparam int SEL_W = $clog2(NUM_KERNELS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture_done,
  output logic                   busy,
  output logic                   cmp_start,
  output logic [SEL_W-1:0]       cmp_sel,
  input  logic                   cmp_done,
  input  logic [SCORE_WIDTH-1:0] cmp_score,
  output logic                   result_valid,
  output logic [SEL_W-1:0]       result_rank,
  output logic [SCORE_WIDTH-1:0] result_score,
  output logic                   result_timeout
`ifdef MATCH_THRESHOLD_EN
  ,output logic                  no_match
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  if (THRESHOLD < 0 || THRESHOLD >= (1 << SCORE_WIDTH)) begin : g_thr_range
    $error("THRESHOLD does not fit in SCORE_WIDTH");
  end
  state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [SCORE_WIDTH-1:0] score_q, score_d;
  logic timeout_q, timeout_d;
  logic clear, upd;
  logic [SCORE_WIDTH-1:0] best_score_nxt;
  logic [SEL_W-1:0] best_idx_nxt;
  logic busy_q, cmp_start_q, result_valid_q, result_timeout_q;
  logic [SEL_W-1:0] result_rank_q;
  logic [SCORE_WIDTH-1:0] result_score_q;
  match_min_tracker #(.SCORE_W(SCORE_WIDTH), .IDX_W(SEL_W)) u_min (
    .clk(clk),
    .rst(rst),
    .clear_i(clear),
    .upd_i(upd),
    .score_i(score_q),
    .idx_i(idx_q),
    .best_score_nxt_o(best_score_nxt),
    .best_idx_nxt_o(best_idx_nxt)
  );
  // pass sequencing: issue, wait with timeout, evaluate, report
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    timer_d = timer_q;
    score_d = score_q;
    timeout_d = timeout_q;
    clear = 1'b0;
    upd = 1'b0;
    unique case (state_q)
      IDLE: if (capture_done) begin
        state_d = ISSUE;
        idx_d = '0;
        timeout_d = 1'b0;
        clear = 1'b1;
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if (cmp_done) begin
          score_d = cmp_score;
          state_d = EVAL;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d = DONE;
        end
      end
      EVAL: begin
        upd = 1'b1;
        state_d = (idx_q == SEL_W'(NUM_KERNELS - 1)) ? DONE : ISSUE;
        idx_d = (idx_q == SEL_W'(NUM_KERNELS - 1)) ? idx_q : idx_q + SEL_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef MATCH_THRESHOLD_EN
  logic no_match_q;
`endif
  // state and registered outputs, which follow the state being entered so they appear with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      timer_q <= '0;
      score_q <= '0;
      timeout_q <= 1'b0;
      busy_q <= 1'b0;
      cmp_start_q <= 1'b0;
      result_valid_q <= 1'b0;
      result_rank_q <= '0;
      result_score_q <= '0;
      result_timeout_q <= 1'b0;
`ifdef MATCH_THRESHOLD_EN
      no_match_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      timer_q <= timer_d;
      score_q <= score_d;
      timeout_q <= timeout_d;
      busy_q <= state_d != IDLE;
      cmp_start_q <= state_d == ISSUE;
      result_valid_q <= state_d == DONE;
      if (state_d == DONE) begin
        result_rank_q <= best_idx_nxt;
        result_score_q <= best_score_nxt;
        result_timeout_q <= timeout_d;
`ifdef MATCH_THRESHOLD_EN
        no_match_q <= (best_score_nxt > SCORE_WIDTH'(THRESHOLD)) || timeout_d;
`endif
      end
    end
  end
  assign busy = busy_q;
  assign cmp_start = cmp_start_q;
  assign cmp_sel = idx_q;
  assign result_valid = result_valid_q;
  assign result_rank = result_rank_q;
  assign result_score = result_score_q;
  assign result_timeout = result_timeout_q;
`ifdef MATCH_THRESHOLD_EN
  assign no_match = no_match_q;
`endif
endmodule
